// File: rtl/pipe_mips32.sv
// pipe_mips32 -- 5-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB).
//
// Unified word-addressed instruction/data memory `Mem` and a 32x32 register
// file `Reg`, both internal; benches preload/inspect them hierarchically.
// PC is a word index; memory is addressed with the low log2(MEM_WORDS) bits.
//
// Ports:
//   clk1    in   sole clock, all state updates on rising edge
//   reset   in   synchronous, active-high; clears PC/HALTED/TAKEN_BRANCH and
//                turns every pipeline latch into a bubble (Reg/Mem untouched)
//   halted  out  mirrors HALTED (set when HLT reaches WB, holds until reset)
//
// Optional feature macro: MIPS_MUL_EN -- when defined, opcode 000101 (MUL)
// writes the low 32 bits of rs*rt to rd; when undefined it decodes as a NOP
// and no multiplier is built.
module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk1,
  input  logic reset,
  output logic halted
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } alu_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic        vld;
    alu_e        alu;
    logic        use_imm;
    logic        wr;
    logic        ld;
    logic        st;
    logic        bnez;
    logic        beqz;
    logic        hlt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic        ld;
    logic        st;
    logic        hlt;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] sd;
  } exmem_t;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic        hlt;
    logic [4:0]  dst;
    logic [31:0] res;
  } memwb_t;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  ifid_t  ifid;
  idex_t  idex,  id_next;
  exmem_t exmem, ex_next;
  memwb_t memwb, mem_next;

  assign halted = HALTED;

  // ---------------- WB ----------------
  logic wb_we;
  assign wb_we = memwb.vld & memwb.wr & (memwb.dst != 5'd0);

  // ---------------- ID ----------------
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] rd_a, rd_b;
  logic        hlt_pending;

  assign id_op = ifid.ir[31:26];
  assign id_rs = ifid.ir[25:21];
  assign id_rt = ifid.ir[20:16];
  assign id_rd = ifid.ir[15:11];

  // Write-first register read: a WB write this cycle is seen by ID.
  assign rd_a = (id_rs == 5'd0) ? 32'd0 :
                (wb_we && memwb.dst == id_rs) ? memwb.res : Reg[id_rs];
  assign rd_b = (id_rt == 5'd0) ? 32'd0 :
                (wb_we && memwb.dst == id_rt) ? memwb.res : Reg[id_rt];

  // Anything younger than an in-flight HLT is squashed as it leaves ID, so
  // nothing fetched behind HLT can ever write Reg/Mem or redirect PC.
  assign hlt_pending = (idex.vld & idex.hlt) | (exmem.vld & exmem.hlt) |
                       (memwb.vld & memwb.hlt);

  always_comb begin
    id_next     = '0;
    id_next.vld = ifid.vld & ~hlt_pending;
    id_next.alu = ALU_ADD;
    id_next.rs  = id_rs;
    id_next.rt  = id_rt;
    id_next.a   = rd_a;
    id_next.b   = rd_b;
    id_next.imm = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
    id_next.npc = ifid.npc;
    case (id_op)
      OP_ADD:   begin id_next.alu = ALU_ADD; id_next.wr = 1'b1; id_next.dst = id_rd; end
      OP_SUB:   begin id_next.alu = ALU_SUB; id_next.wr = 1'b1; id_next.dst = id_rd; end
      OP_AND:   begin id_next.alu = ALU_AND; id_next.wr = 1'b1; id_next.dst = id_rd; end
      OP_OR:    begin id_next.alu = ALU_OR;  id_next.wr = 1'b1; id_next.dst = id_rd; end
      OP_SLT:   begin id_next.alu = ALU_SLT; id_next.wr = 1'b1; id_next.dst = id_rd; end
`ifdef MIPS_MUL_EN
      OP_MUL:   begin id_next.alu = ALU_MUL; id_next.wr = 1'b1; id_next.dst = id_rd; end
`endif
      OP_ADDI:  begin id_next.alu = ALU_ADD; id_next.use_imm = 1'b1; id_next.wr = 1'b1; id_next.dst = id_rt; end
      OP_SUBI:  begin id_next.alu = ALU_SUB; id_next.use_imm = 1'b1; id_next.wr = 1'b1; id_next.dst = id_rt; end
      OP_SLTI:  begin id_next.alu = ALU_SLT; id_next.use_imm = 1'b1; id_next.wr = 1'b1; id_next.dst = id_rt; end
      OP_LW:    begin id_next.use_imm = 1'b1; id_next.wr = 1'b1; id_next.ld = 1'b1; id_next.dst = id_rt; end
      OP_SW:    begin id_next.use_imm = 1'b1; id_next.st = 1'b1; end
      OP_BNEQZ: id_next.bnez = 1'b1;
      OP_BEQZ:  id_next.beqz = 1'b1;
      OP_HLT:   id_next.hlt  = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- EX ----------------
  // Forwarding priority EX/MEM over MEM/WB. EX/MEM never forwards load data
  // (it is not read yet); a dependent op right after LW is the program's problem.
  logic        exm_fwd;
  logic [31:0] fa, fb, opb, alu_y, br_tgt;
  logic        br_taken;

  assign exm_fwd = exmem.vld & exmem.wr & ~exmem.ld & (exmem.dst != 5'd0);

  assign fa = (exm_fwd && exmem.dst == idex.rs) ? exmem.alu :
              (wb_we   && memwb.dst == idex.rs) ? memwb.res : idex.a;
  assign fb = (exm_fwd && exmem.dst == idex.rt) ? exmem.alu :
              (wb_we   && memwb.dst == idex.rt) ? memwb.res : idex.b;
  assign opb = idex.use_imm ? idex.imm : fb;

  always_comb begin
    alu_y = '0;
    case (idex.alu)
      ALU_ADD: alu_y = fa + opb;
      ALU_SUB: alu_y = fa - opb;
      ALU_AND: alu_y = fa & opb;
      ALU_OR:  alu_y = fa | opb;
      ALU_SLT: alu_y = {31'd0, $signed(fa) < $signed(opb)};
`ifdef MIPS_MUL_EN
      ALU_MUL: alu_y = fa * opb;
`endif
      default: alu_y = '0;
    endcase
  end

  assign br_taken = idex.vld & ((idex.bnez & (fa != 32'd0)) | (idex.beqz & (fa == 32'd0)));
  assign br_tgt   = idex.npc + idex.imm;

  always_comb begin
    ex_next     = '0;
    ex_next.vld = idex.vld;
    ex_next.wr  = idex.vld & idex.wr;
    ex_next.ld  = idex.vld & idex.ld;
    ex_next.st  = idex.vld & idex.st;
    ex_next.hlt = idex.vld & idex.hlt;
    ex_next.dst = idex.dst;
    ex_next.alu = alu_y;
    ex_next.sd  = fb;
  end

  // ---------------- MEM ----------------
  always_comb begin
    mem_next     = '0;
    mem_next.vld = exmem.vld;
    mem_next.wr  = exmem.wr;
    mem_next.hlt = exmem.hlt;
    mem_next.dst = exmem.dst;
    mem_next.res = exmem.ld ? Mem[exmem.alu[AW-1:0]] : exmem.alu;
  end

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      ifid         <= '0;
      idex         <= '0;
      exmem        <= '0;
      memwb        <= '0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= br_taken;
      if (br_taken) begin
        PC   <= br_tgt;
        ifid <= '0;
        idex <= '0;
      end else begin
        PC   <= PC + 32'd1;
        ifid <= '{vld: 1'b1, ir: Mem[PC[AW-1:0]], npc: PC + 32'd1};
        idex <= id_next;
      end
      exmem <= ex_next;
      memwb <= mem_next;
      if (memwb.vld && memwb.hlt) HALTED <= 1'b1;
    end
  end

  // Architectural writes: blocked during reset (in-flight work is discarded)
  // and while halted.
  always_ff @(posedge clk1) begin
    if (!reset && !HALTED) begin
      if (wb_we) Reg[memwb.dst] <= memwb.res;
      if (exmem.vld && exmem.st) Mem[exmem.alu[AW-1:0]] <= exmem.sd;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed bench for pipe_mips32: preloads Mem/Reg hierarchically, runs small
// programs to HLT and checks architectural state, cycle counts and branch pulses.
module tb_pipe_mips32;
  localparam int MEM_WORDS = 1024;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010,
                         OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101,
                         OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic clk1, reset, halted;
  int   ncmp = 0, nfail = 0;
  int   cyc, tk;
  logic [31:0] pc_frz;

  pipe_mips32 #(.MEM_WORDS(MEM_WORDS)) dut (.clk1(clk1), .reset(reset), .halted(halted));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset across one rising edge and wipe Mem/Reg for a fresh program.
  task automatic begin_test();
    reset = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    for (int i = 0; i < MEM_WORDS; i++) dut.Mem[i] <= 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] <= 32'd0;
  endtask

  // Release reset and count rising edges until halted is seen (bounded).
  task automatic run_to_halt(input int budget, output int cycles, output int taken);
    cycles = 0;
    taken  = 0;
    reset  = 1'b0;
    while (cycles < budget) begin
      @(posedge clk1);
      cycles++;
      @(negedge clk1);
      if (dut.TAKEN_BRANCH === 1'b1) taken++;
      if (halted === 1'b1) break;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    chk("rst_pc", dut.PC, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // 1: load/add/store with one spacer after LW
    begin_test();
    for (int k = 0; k < 32; k++) dut.Reg[k] <= 32'(k);
    dut.Mem[0] <= ri(OP_ADDI, 1, 0, 120);
    dut.Mem[1] <= rr(OP_OR, 3, 3, 3);
    dut.Mem[2] <= ri(OP_LW, 2, 1, 0);
    dut.Mem[3] <= rr(OP_OR, 3, 3, 3);
    dut.Mem[4] <= ri(OP_ADDI, 2, 2, 45);
    dut.Mem[5] <= rr(OP_OR, 3, 3, 3);
    dut.Mem[6] <= ri(OP_SW, 2, 1, 1);
    dut.Mem[7] <= HLT;
    dut.Mem[120] <= 32'd85;
    run_to_halt(50, cyc, tk);
    chk("t1_mem120", dut.Mem[120], 32'd85);
    chk("t1_mem121", dut.Mem[121], 32'd130);
    chk("t1_r2", dut.Reg[2], 32'd130);
    chk("t1_r3", dut.Reg[3], 32'd3);
    chk("t1_cycles", 32'(cyc), 32'd12);

    // 2: back-to-back forwarding
    begin_test();
    dut.Mem[0] <= ri(OP_ADDI, 1, 0, 10);
    dut.Mem[1] <= ri(OP_ADDI, 2, 0, 20);
    dut.Mem[2] <= rr(OP_ADD, 3, 1, 2);
    dut.Mem[3] <= rr(OP_SUB, 4, 3, 1);
    dut.Mem[4] <= HLT;
    run_to_halt(50, cyc, tk);
    chk("t2_r3", dut.Reg[3], 32'd30);
    chk("t2_r4", dut.Reg[4], 32'd20);
    chk("t2_cycles", 32'(cyc), 32'd9);

    // 3: countdown loop; R13 counts fall-through commits after BNEQZ
    begin_test();
    dut.Mem[0] <= ri(OP_ADDI, 10, 0, 7);
    dut.Mem[1] <= ri(OP_ADDI, 11, 0, 0);
    dut.Mem[2] <= rr(OP_ADD, 11, 11, 10);
    dut.Mem[3] <= ri(OP_SUBI, 10, 10, 1);
    dut.Mem[4] <= ri(OP_BNEQZ, 0, 10, -3);
    dut.Mem[5] <= ri(OP_ADDI, 13, 13, 1);
    dut.Mem[6] <= HLT;
    run_to_halt(200, cyc, tk);
    chk("t3_r11", dut.Reg[11], 32'd28);
    chk("t3_r10", dut.Reg[10], 32'd0);
    chk("t3_r13", dut.Reg[13], 32'd1);
    chk("t3_taken", 32'(tk), 32'd6);
    chk("t3_cycles", 32'(cyc), 32'd41);

    // 4: signed compares, wraparound, R0 hard-wired
    begin_test();
    dut.Mem[0] <= ri(OP_ADDI, 1, 0, -1);
    dut.Mem[1] <= ri(OP_ADDI, 2, 0, 1);
    dut.Mem[2] <= rr(OP_SLT, 3, 1, 2);
    dut.Mem[3] <= ri(OP_SUBI, 5, 0, 1);
    dut.Mem[4] <= ri(OP_ADDI, 0, 0, 5);
    dut.Mem[5] <= rr(OP_ADD, 4, 0, 2);
    dut.Mem[6] <= ri(OP_SLTI, 8, 2, -1);
    dut.Mem[7] <= rr(OP_SLT, 9, 2, 1);
    dut.Mem[8] <= rr(OP_AND, 6, 1, 2);
    dut.Mem[9] <= HLT;
    run_to_halt(50, cyc, tk);
    chk("t4_slt", dut.Reg[3], 32'd1);
    chk("t4_subi", dut.Reg[5], 32'hFFFF_FFFF);
    chk("t4_r0", dut.Reg[0], 32'd0);
    chk("t4_r0_fwd", dut.Reg[4], 32'd1);
    chk("t4_slti", dut.Reg[8], 32'd0);
    chk("t4_slt_rev", dut.Reg[9], 32'd0);
    chk("t4_and", dut.Reg[6], 32'd1);

    // 5: HLT first; younger ops never commit; frozen while halted; restart
    begin_test();
    dut.Reg[6]   <= 32'd5;
    dut.Mem[0]   <= HLT;
    dut.Mem[1]   <= ri(OP_ADDI, 6, 0, 99);
    dut.Mem[2]   <= ri(OP_SW, 6, 0, 200);
    dut.Mem[200] <= 32'h0000_1234;
    run_to_halt(50, cyc, tk);
    chk("t5_cycles", 32'(cyc), 32'd5);
    chk("t5_r6", dut.Reg[6], 32'd5);
    chk("t5_pc", dut.PC, 32'd5);
    pc_frz = dut.PC;
    repeat (10) @(negedge clk1);
    chk("t5_pc_frozen", dut.PC, pc_frz);
    chk("t5_still_halted", {31'd0, halted}, 32'd1);
    chk("t5_mem200", dut.Mem[200], 32'h0000_1234);
    reset = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    chk("t5_rst_pc", dut.PC, 32'd0);
    chk("t5_rst_halted", {31'd0, halted}, 32'd0);
    dut.Mem[0] <= ri(OP_ADDI, 14, 0, 33);
    dut.Mem[1] <= HLT;
    run_to_halt(50, cyc, tk);
    chk("t5_restart_r14", dut.Reg[14], 32'd33);
    chk("t5_restart_r6", dut.Reg[6], 32'd5);

    // 6: MUL, build-dependent
    begin_test();
    dut.Reg[7] <= 32'h55;
    dut.Mem[0] <= ri(OP_ADDI, 1, 0, 6);
    dut.Mem[1] <= ri(OP_ADDI, 2, 0, 7);
    dut.Mem[2] <= rr(OP_MUL, 7, 1, 2);
    dut.Mem[3] <= HLT;
    run_to_halt(50, cyc, tk);
`ifdef MIPS_MUL_EN
    chk("t6_mul", dut.Reg[7], 32'd42);
`else
    chk("t6_mul_nop", dut.Reg[7], 32'h55);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_mips32.md
Name: pipe_mips32

Overview:
- Single-clock, 5-stage in-order MIPS32-subset processor: IF, ID, EX, MEM, WB.
- Contains a unified instruction/data word memory and a 32x32 register file.
- Register file, memory and control state are internal arrays. Benches preload and inspect them hierarchically; there is no bus interface.
- Top-level compute core of the test system.

Parameters:
- MEM_WORDS, 1024, depth of unified memory `Mem` (word-addressed; PC and effective addresses use low log2(MEM_WORDS) bits).

Ports:
- clk1  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- halted  output  1  mirrors internal `HALTED`.

Behaviour:
Internal names, fixed because benches reference them hierarchically:
- `Reg[0:31]` (32b).
- `Mem[0:MEM_WORDS-1]` (32b).
- `PC` (32b, word index).
- `HALTED`.
- `TAKEN_BRANCH`.

Reset:
- Sets PC=0, HALTED=0, TAKEN_BRANCH=0.
- All pipeline latches become bubbles (no writes).
- Reg and Mem are NOT cleared.

Encoding:
- opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], sign-extended to 32b.
- RR ops (rd = rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
- RI ops (rt = rs op imm): ADDI 001010, SUBI 001011, SLTI 001100.
- LW 001000: rt = Mem[rs+imm].
- SW 001001: Mem[rs+imm] = rt.
- BNEQZ 001101 / BEQZ 001110: if rs!=0 / rs==0, PC = (branch PC+1) + imm.
- HLT 111111.
- Any other opcode is a NOP.

Arithmetic:
- 32b two's-complement wraparound.
- SLT/SLTI: signed compare; result 1 or 0.

Register file:
- R0 reads 0; writes to R0 are discarded.
- ID reads are write-first: a WB write in the same cycle is visible to ID.

Pipeline and hazards:
- One instruction enters per cycle; PC += 1 per fetch.
- Forwarding into EX operands, priority EX/MEM over MEM/WB:
  - EX/MEM supplies ALU results.
  - MEM/WB supplies ALU results and load data.
- A dependent instruction immediately after LW is not interlocked; its result is unspecified. Software inserts one independent instruction.
- SW store data is taken through the same forwarding paths.

Branches:
- Resolved in EX.
- If taken: PC <= target at end of that cycle, IF/ID and ID/EX become bubbles, TAKEN_BRANCH pulses 1 for one cycle.
- If not taken: no penalty.

Memory:
- SW writes Mem in MEM stage.
- IF reads the same array.
- Self-modifying code is visible only after the write commits.

HLT:
- When HLT reaches WB, HALTED <= 1.
- While HALTED, no state changes (PC, latches, Reg, Mem) until reset.
- Instructions after HLT never commit.

Reset mid-operation:
- In-flight instructions are discarded.
- A write already committed in WB/MEM before the reset edge persists.

Optional Feature:
- Macro MIPS_MUL_EN.
  - Defined: MUL writes the low 32 bits of rs*rt to rd.
  - Undefined: opcode 000101 is a NOP (no register write) and no multiplier is built.

Test Plan:
1. Preload Reg[k]=k. Run program:
   - ADDI R1,R0,120
   - OR R3,R3,R3
   - LW R2,0(R1)
   - OR R3,R3,R3
   - ADDI R2,R2,45
   - OR R3,R3,R3
   - SW R2,1(R1)
   - HLT
   With Mem[120]=85, assert reset one cycle and run 50 cycles -> Mem[120]=85, Mem[121]=130, halted=1.
2. Back-to-back dependency, no dummies: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; HLT -> R3=30, R4=20 (forwarding).
3. Loop: R10=7; BNEQZ loop decrementing R10 and summing into R11 -> R11=28, R10=0. Exactly 2 bubbles per taken branch; post-branch fall-through instructions never commit.
4. Signed ops: SLT with R1=-1, R2=1 -> 1. SUBI R5,R0,1 -> 0xFFFFFFFF. ADDI R0,R0,5 -> R0 stays 0.
5. HLT followed by ADDI R6,R0,99 -> R6 unchanged. PC and Mem frozen while halted. Reset then restarts from PC=0.
6. MIPS_MUL_EN: MUL R7,R1,R2 with R1=6, R2=7 -> R7=42 when defined; R7 unchanged when undefined.
